// File: rtl/logic_arb_pkg.sv
// Shared opcode encodings, operand width default and op type for the logic-unit arbiter.
package logic_arb_pkg;

  localparam int WIDTH_DEF = 32;

  typedef logic [1:0] op_t;

  localparam op_t OP_AND = 2'b00;
  localparam op_t OP_OR  = 2'b01;
  localparam op_t OP_XOR = 2'b10;
  localparam op_t OP_NOR = 2'b11;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational four-op bitwise unit (AND/OR/XOR/NOR); zero latency, no flow control.
module logic_unit_core
  import logic_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin share of one logic unit between two requesters; result registered (1 cycle),
// single-entry output buffer stalls both requesters when full and not draining. Option: LOGIC_ARB_STATS_EN.
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
`ifdef LOGIC_ARB_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  op_t              req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  op_t              req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready
`ifdef LOGIC_ARB_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] gnt0_cnt,
  output logic [CNT_W-1:0] gnt1_cnt
`endif
);

  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_prio;

  logic             w_can_accept;
  logic             w_gnt0;
  logic             w_gnt1;
  op_t              w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_y;

  // Buffer can take a new result if empty or being drained this cycle.
  assign w_can_accept = !r_rsp_valid || rsp_ready;
  assign w_gnt0 = w_can_accept && req0_valid && (!req1_valid || !r_prio);
  assign w_gnt1 = w_can_accept && req1_valid && (!req0_valid ||  r_prio);

  assign w_op = w_gnt1 ? req1_op : req0_op;
  assign w_a  = w_gnt1 ? req1_a  : req0_a;
  assign w_b  = w_gnt1 ? req1_b  : req0_b;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op (w_op),
    .a  (w_a),
    .b  (w_b),
    .y  (w_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_prio      <= 1'b0;
    end else if (w_gnt0 || w_gnt1) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_gnt1;
      r_rsp_data  <= w_y;
      r_prio      <= w_gnt0;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;

`ifdef LOGIC_ARB_STATS_EN
  logic [CNT_W-1:0] r_gnt0_cnt;
  logic [CNT_W-1:0] r_gnt1_cnt;

  // Saturating grant counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt0_cnt <= '0;
      r_gnt1_cnt <= '0;
    end else if (stats_clr) begin
      r_gnt0_cnt <= '0;
      r_gnt1_cnt <= '0;
    end else begin
      if (w_gnt0 && (r_gnt0_cnt != '1)) r_gnt0_cnt <= r_gnt0_cnt + 1'b1;
      if (w_gnt1 && (r_gnt1_cnt != '1)) r_gnt1_cnt <= r_gnt1_cnt + 1'b1;
    end
  end

  assign gnt0_cnt = r_gnt0_cnt;
  assign gnt1_cnt = r_gnt1_cnt;
`endif

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters, e.g. the ALU-issue path and a debug/test port.
- Arbitration is round-robin with valid/ready handshakes on both requesters and on the response side.
- The result is registered: one cycle of latency, plus a single-entry output buffer that supports backpressure.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_op  in  2  requester 0 opcode.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req0_ready  out  1  requester 0 accepted this cycle (combinational grant).
- req1_valid, req1_op, req1_a, req1_b, req1_ready: same as requester 0, for requester 1.
- rsp_valid  out  1  output buffer holds a result.
- rsp_id  out  1  requester index that owns rsp_data.
- rsp_data  out  WIDTH  result.
- rsp_ready  in  1  consumer takes the result this cycle.

Behaviour:
- Opcodes: 00 AND, 01 OR, 10 XOR, 11 NOR (bitwise over WIDTH bits).
- Reset (async, active-high) sets rsp_valid=0, rsp_id=0, rsp_data=0 and priority pointer prio=0 (requester 0 preferred). Asserting reset mid-operation discards any buffered result immediately.
- can_accept = !rsp_valid || rsp_ready. When output is full and not draining, no grant: both reqN_ready=0.
- Grant when can_accept:
  - only one valid → grant it;
  - both valid → grant requester prio.
- reqN_ready is combinational from reqN_valid, prio, rsp_valid and rsp_ready. It never asserts without reqN_valid, and at most one ready is high per cycle.
- Transfer occurs when reqN_valid && reqN_ready. On the following edge:
  - rsp_data <= op(a,b);
  - rsp_id <= N;
  - rsp_valid <= 1;
  - prio <= ~N (the winner loses priority).
- Prio changes only on a transfer, never on idle cycles.
- Drain without a new transfer (rsp_valid && rsp_ready, no grant): rsp_valid <= 0; rsp_data and rsp_id hold.
- Simultaneous drain and grant in the same cycle: new result loaded, rsp_valid stays 1. Full throughput is one op per cycle.
- While rsp_valid && !rsp_ready: rsp_data and rsp_id are stable.
- Requester inputs need not be stable after a transfer. The unit samples them only in the grant cycle.
- Latency: the result is visible exactly one cycle after the transfer cycle.

Optional Feature:
- Macro: LOGIC_ARB_STATS_EN.
- Defined: adds outputs gnt0_cnt and gnt1_cnt (each CNT_W bits) and input stats_clr.
  - Each counter increments on its requester's transfer and saturates at all-ones (no wrap).
  - stats_clr zeroes both counters synchronously and has priority over an increment in the same cycle.
  - reset also zeroes both counters.
- Undefined: these ports and this logic are absent; behaviour is otherwise identical.

Decomposition:
- Package logic_arb_pkg holds:
  - opcode localparams OP_AND, OP_OR, OP_XOR, OP_NOR;
  - default WIDTH;
  - a 2-bit op typedef.
- Sub-module logic_unit_core: purely combinational WIDTH-bit four-op unit (op, a, b → y). It is instantiated once on the muxed granted operands.
- Arbiter, grant mux, output buffer and prio register stay in the top.

Test Plan:
1. After reset, only req0_valid=1, op=01, a=0x0000FFFF, b=0xFFFF0000 → req0_ready=1 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=0xFFFFFFFF.
2. Both valid every cycle, rsp_ready=1:
   - req0 op=00, a=0xFFFFFFFF, b=0x0003FFFF;
   - req1 op=10, a=0xAAAAAAAA, b=0xFFFFFFFF;
   - expected: grants alternate 0,1,0,1; rsp_data alternates 0x0003FFFF / 0x55555555; one result per cycle.
3. Backpressure: rsp_ready=0 with a result held and req1_valid=1 → req1_ready=0 and rsp_data stable for 3 cycles. Raising rsp_ready → req1 granted that cycle, new result next cycle, rsp_valid never drops.
4. req0 op=11, a=0, b=0 → rsp_data=0xFFFFFFFF. Then assert reset while rsp_valid=1 → rsp_valid=0 and rsp_data=0 immediately (asynchronously). After release, prio=0: with both valid, req0 wins.
5. With LOGIC_ARB_STATS_EN and CNT_W=4:
   - 20 req1 transfers → gnt1_cnt=15 (saturated), gnt0_cnt=0;
   - stats_clr pulsed together with a transfer → both counters 0.
